// File: rtl/ahb_rr_burst_arbiter_if.sv
// rtl/ahb_rr_burst_arbiter_if.sv - AHB arbiter request/grant bundle
// HSPLIT exists only when AHB_ARB_SPLIT_EN is defined.
interface ahb_rr_burst_arbiter_if #(
  parameter int NUM_MASTERS = 3,
  parameter int MASTER_BITS = 4
);
  logic [NUM_MASTERS-1:0] HBUSREQ;
  logic [NUM_MASTERS-1:0] HLOCK;
  logic [1:0]             HTRANS;
  logic [2:0]             HBURST;
  logic                   HREADY;
  logic [1:0]             HRESP;
`ifdef AHB_ARB_SPLIT_EN
  logic [NUM_MASTERS-1:0] HSPLIT;
`endif
  logic [NUM_MASTERS-1:0] HGRANT;
  logic [MASTER_BITS-1:0] HMASTER;
  logic                   HMASTLOCK;

  modport master (
    output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
`ifdef AHB_ARB_SPLIT_EN
    output HSPLIT,
`endif
    input  HGRANT, HMASTER, HMASTLOCK
  );

  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
`ifdef AHB_ARB_SPLIT_EN
    input  HSPLIT,
`endif
    output HGRANT, HMASTER, HMASTLOCK
  );
endinterface

// File: rtl/ahb_rr_burst_arbiter.sv
// rtl/ahb_rr_burst_arbiter.sv - round-robin, burst- and lock-aware AHB arbiter
// Optional AHB_ARB_SPLIT_EN adds split masking; otherwise SPLIT behaves as RETRY.
module ahb_rr_burst_arbiter #(
  parameter int NUM_MASTERS    = 3,
  parameter int DEFAULT_MASTER = 0,
  parameter int MASTER_BITS    = 4
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahb_rr_burst_arbiter_if.slave bus
);
  localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_BUSY   = 2'd1;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;
  localparam logic [1:0] RSP_RETRY = 2'd2;
  localparam logic [1:0] RSP_SPLIT = 2'd3;

  localparam logic [NUM_MASTERS-1:0] DEFAULT_GNT = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [PTR_W-1:0]       DEFAULT_PTR = PTR_W'(DEFAULT_MASTER);
  localparam logic [MASTER_BITS-1:0] DEFAULT_MST = MASTER_BITS'(DEFAULT_MASTER);

  typedef enum logic [1:0] {GNT_IDLE, GNT_OWN, GNT_BURST, GNT_LOCK} state_t;

  state_t                 state, state_nxt;
  logic [NUM_MASTERS-1:0] grant, grant_nxt;
  logic [PTR_W-1:0]       rr_ptr, rr_ptr_nxt;
  logic [3:0]             beat_cnt, beat_cnt_nxt;
  logic [MASTER_BITS-1:0] master_q, master_nxt;
  logic                   mastlock_q, mastlock_nxt;

  logic [PTR_W-1:0]       grant_idx;
  logic [NUM_MASTERS-1:0] eligible;
  logic                   win_found;
  logic [PTR_W-1:0]       win_idx;
  int                     scan_idx;
  logic [3:0]             burst_len;
  logic                   burst_start;
  logic                   retry_2nd;
  logic                   split_2nd;
  logic                   lock_release;
  logic                   normal_arb;
  logic                   force_arb;
  logic                   arb_ok;

`ifdef AHB_ARB_SPLIT_EN
  logic [NUM_MASTERS-1:0] split_mask, split_mask_nxt;
  logic [NUM_MASTERS-1:0] split_set;

  // The master being split is excluded from the very arbitration it triggers.
  always_comb begin
    split_set = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (split_2nd && master_q == MASTER_BITS'(i) && i != DEFAULT_MASTER)
        split_set[i] = 1'b1;
    end
    split_mask_nxt = (split_mask & ~bus.HSPLIT) | split_set;
    eligible       = bus.HBUSREQ & ~(split_mask | split_set);
  end

  assign split_2nd = bus.HREADY && (bus.HRESP == RSP_SPLIT);
`else
  assign eligible  = bus.HBUSREQ;
  assign split_2nd = 1'b0;
`endif

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant[i])
        grant_idx = PTR_W'(i);
    end
  end

  // Scan farthest-first so the nearest requester after rr_ptr is the last write.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr;
    scan_idx  = 0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= NUM_MASTERS)
        scan_idx = scan_idx - NUM_MASTERS;
      if (eligible[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(scan_idx);
      end
    end
  end

  always_comb begin
    case (bus.HBURST)
      3'd2, 3'd3: burst_len = 4'd3;
      3'd4, 3'd5: burst_len = 4'd7;
      3'd6, 3'd7: burst_len = 4'd15;
      default:    burst_len = 4'd0;
    endcase
  end

  // A fixed burst starting this cycle already counts as a burst in progress.
  assign burst_start  = bus.HREADY && (bus.HTRANS == TR_NONSEQ) && (burst_len != 4'd0);
  assign retry_2nd    = bus.HREADY && ((bus.HRESP == RSP_RETRY) || (bus.HRESP == RSP_SPLIT));
  assign lock_release = (state == GNT_LOCK) && bus.HREADY && !bus.HLOCK[grant_idx] &&
                        (bus.HTRANS != TR_SEQ) && (bus.HTRANS != TR_BUSY);
  assign normal_arb   = bus.HREADY && (state != GNT_LOCK) && !burst_start &&
                        ((state != GNT_BURST) || (beat_cnt == 4'd1));
  assign force_arb    = retry_2nd && ((state != GNT_LOCK) || split_2nd);
  assign arb_ok       = normal_arb || lock_release || force_arb;

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    master_nxt   = master_q;
    mastlock_nxt = mastlock_q;

    if (bus.HREADY) begin
      master_nxt   = MASTER_BITS'(grant_idx);
      mastlock_nxt = bus.HLOCK[grant_idx];
    end

    if (arb_ok) begin
      beat_cnt_nxt = '0;
      if (win_found) begin
        grant_nxt  = NUM_MASTERS'(1) << win_idx;
        rr_ptr_nxt = win_idx;
        state_nxt  = bus.HLOCK[win_idx] ? GNT_LOCK : GNT_OWN;
      end else begin
        grant_nxt  = DEFAULT_GNT;
        state_nxt  = GNT_IDLE;
      end
    end else if (retry_2nd) begin
      // Retry inside a locked sequence keeps the lock; only the count resets.
      beat_cnt_nxt = '0;
    end else if (burst_start) begin
      beat_cnt_nxt = burst_len;
      if (state != GNT_LOCK)
        state_nxt = GNT_BURST;
    end else if (bus.HREADY && beat_cnt != 4'd0) begin
      if (bus.HTRANS == TR_SEQ) begin
        beat_cnt_nxt = beat_cnt - 4'd1;
      end else if (bus.HTRANS == TR_IDLE || bus.HTRANS == TR_NONSEQ) begin
        beat_cnt_nxt = '0;
        if (state == GNT_BURST)
          state_nxt = GNT_OWN;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= GNT_IDLE;
      grant      <= DEFAULT_GNT;
      rr_ptr     <= DEFAULT_PTR;
      beat_cnt   <= '0;
      master_q   <= DEFAULT_MST;
      mastlock_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      rr_ptr     <= rr_ptr_nxt;
      beat_cnt   <= beat_cnt_nxt;
      master_q   <= master_nxt;
      mastlock_q <= mastlock_nxt;
    end
  end

`ifdef AHB_ARB_SPLIT_EN
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      split_mask <= '0;
    else
      split_mask <= split_mask_nxt;
  end
`endif

  assign bus.HGRANT    = grant;
  assign bus.HMASTER   = master_q;
  assign bus.HMASTLOCK = mastlock_q;
endmodule

// File: tb/tb_ahb_rr_burst_arbiter.sv
// tb/tb_ahb_rr_burst_arbiter.sv - vector-table bench for ahb_rr_burst_arbiter
// Build with AHB_ARB_SPLIT_EN defined to exercise split masking.
module tb_ahb_rr_burst_arbiter;
  localparam logic [1:0] IDL = 2'd0, BSY = 2'd1, NS = 2'd2, SQ = 2'd3;
  localparam logic [1:0] OK = 2'd0, RTY = 2'd2, SPL = 2'd3;
  localparam logic [2:0] SGL = 3'd0, INC4 = 3'd3, INC8 = 3'd5, INC16 = 3'd7;

  typedef struct {
    logic [2:0] req;
    logic [2:0] lock;
    logic [1:0] trans;
    logic [2:0] burst;
    logic       ready;
    logic [1:0] resp;
    logic [2:0] split;
    logic [2:0] g;
    logic [3:0] m;
    logic       ml;
  } vec_t;

  typedef struct {
    logic [2:0] g;
    logic [3:0] m;
    logic       ml;
  } exp_t;

  logic HCLK;
  logic HRESETn;
  int   n_vec = 0;
  int   n_bad = 0;
  int   retry_idx = -1;
  vec_t vt[$];
  exp_t sb[$];

  ahb_rr_burst_arbiter_if #(.NUM_MASTERS(3), .MASTER_BITS(4)) bus ();

  ahb_rr_burst_arbiter #(
    .NUM_MASTERS(3), .DEFAULT_MASTER(0), .MASTER_BITS(4)
  ) dut (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .bus(bus.slave)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  task automatic add(input logic [2:0] req, input logic [2:0] lock, input logic [1:0] trans,
                     input logic [2:0] burst, input logic ready, input logic [1:0] resp,
                     input logic [2:0] split, input logic [2:0] g, input logic [3:0] m,
                     input logic ml);
    vec_t v;
    v.req = req; v.lock = lock; v.trans = trans; v.burst = burst; v.ready = ready;
    v.resp = resp; v.split = split; v.g = g; v.m = m; v.ml = ml;
    vt.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    bus.HBUSREQ = v.req;
    bus.HLOCK   = v.lock;
    bus.HTRANS  = v.trans;
    bus.HBURST  = v.burst;
    bus.HREADY  = v.ready;
    bus.HRESP   = v.resp;
`ifdef AHB_ARB_SPLIT_EN
    bus.HSPLIT  = v.split;
`endif
  endtask

  task automatic apply(input vec_t v, input string nm);
    exp_t e;
    e.g = v.g; e.m = v.m; e.ml = v.ml;
    drive(v);
    sb.push_back(e);
    @(posedge HCLK);
    #1;
    e = sb.pop_front();
    n_vec++;
    if (bus.HGRANT !== e.g || bus.HMASTER !== e.m || bus.HMASTLOCK !== e.ml) begin
      n_bad++;
      $display("FAIL %s: grant=%b master=%0d mastlock=%b, expected grant=%b master=%0d mastlock=%b",
               nm, bus.HGRANT, bus.HMASTER, bus.HMASTLOCK, e.g, e.m, e.ml);
    end
  endtask

  task automatic cmp(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    vec_t v;

    // Idle after reset: default master keeps the bus
    add(3'b000, 3'b000, IDL, SGL,  1, OK, 3'b000, 3'b001, 0, 0);
    add(3'b000, 3'b000, IDL, SGL,  1, OK, 3'b000, 3'b001, 0, 0);
    // Fairness: all request, single transfers
    add(3'b111, 3'b000, NS,  SGL,  1, OK, 3'b000, 3'b010, 0, 0);
    add(3'b111, 3'b000, NS,  SGL,  1, OK, 3'b000, 3'b100, 1, 0);
    add(3'b111, 3'b000, NS,  SGL,  1, OK, 3'b000, 3'b001, 2, 0);
    add(3'b111, 3'b000, NS,  SGL,  1, OK, 3'b000, 3'b010, 0, 0);
    add(3'b111, 3'b000, NS,  SGL,  1, OK, 3'b000, 3'b100, 1, 0);
    // Burst hold: M1 INCR4 with waited beats, M2 requesting
    add(3'b010, 3'b000, IDL, SGL,  1, OK, 3'b000, 3'b010, 2, 0);
    add(3'b010, 3'b000, IDL, SGL,  1, OK, 3'b000, 3'b010, 1, 0);
    add(3'b110, 3'b000, NS,  INC4, 1, OK, 3'b000, 3'b010, 1, 0);
    add(3'b110, 3'b000, SQ,  INC4, 1, OK, 3'b000, 3'b010, 1, 0);
    add(3'b110, 3'b000, SQ,  INC4, 0, OK, 3'b000, 3'b010, 1, 0);
    add(3'b110, 3'b000, SQ,  INC4, 1, OK, 3'b000, 3'b010, 1, 0);
    add(3'b110, 3'b000, SQ,  INC4, 0, OK, 3'b000, 3'b010, 1, 0);
    add(3'b110, 3'b000, SQ,  INC4, 1, OK, 3'b000, 3'b100, 1, 0);
    add(3'b100, 3'b000, IDL, SGL,  1, OK, 3'b000, 3'b100, 2, 0);
    // Lock: M2 three locked singles while M1 requests
    add(3'b100, 3'b100, IDL, SGL,  1, OK, 3'b000, 3'b100, 2, 1);
    add(3'b110, 3'b100, NS,  SGL,  1, OK, 3'b000, 3'b100, 2, 1);
    add(3'b110, 3'b100, NS,  SGL,  1, OK, 3'b000, 3'b100, 2, 1);
    add(3'b110, 3'b000, NS,  SGL,  1, OK, 3'b000, 3'b010, 2, 0);
    add(3'b010, 3'b000, IDL, SGL,  1, OK, 3'b000, 3'b010, 1, 0);
    // RETRY on beat 3 of M1 INCR8
    add(3'b110, 3'b000, NS,  INC8, 1, OK, 3'b000, 3'b010, 1, 0);
    add(3'b110, 3'b000, SQ,  INC8, 1, OK, 3'b000, 3'b010, 1, 0);
    add(3'b110, 3'b000, SQ,  INC8, 1, OK, 3'b000, 3'b010, 1, 0);
    add(3'b110, 3'b000, SQ,  INC8, 0, RTY, 3'b000, 3'b010, 1, 0);
    retry_idx = vt.size();
    add(3'b110, 3'b000, IDL, INC8, 1, RTY, 3'b000, 3'b100, 1, 0);
    add(3'b100, 3'b000, IDL, SGL,  1, OK, 3'b000, 3'b100, 2, 0);
    // SPLIT on an M1 single, M1 the only requester
    add(3'b010, 3'b000, IDL, SGL,  1, OK, 3'b000, 3'b010, 2, 0);
    add(3'b010, 3'b000, NS,  SGL,  1, OK, 3'b000, 3'b010, 1, 0);
    add(3'b010, 3'b000, IDL, SGL,  0, SPL, 3'b000, 3'b010, 1, 0);
`ifdef AHB_ARB_SPLIT_EN
    add(3'b010, 3'b000, IDL, SGL,  1, SPL, 3'b000, 3'b001, 1, 0);
    add(3'b010, 3'b000, IDL, SGL,  1, OK, 3'b000, 3'b001, 0, 0);
    add(3'b010, 3'b000, IDL, SGL,  1, OK, 3'b010, 3'b001, 0, 0);
    add(3'b010, 3'b000, IDL, SGL,  1, OK, 3'b000, 3'b010, 0, 0);
`else
    add(3'b010, 3'b000, IDL, SGL,  1, SPL, 3'b000, 3'b010, 1, 0);
    add(3'b010, 3'b000, IDL, SGL,  1, OK, 3'b000, 3'b010, 1, 0);
    add(3'b010, 3'b000, IDL, SGL,  1, OK, 3'b000, 3'b010, 1, 0);
    add(3'b010, 3'b000, IDL, SGL,  1, OK, 3'b000, 3'b010, 1, 0);
`endif
    add(3'b010, 3'b000, IDL, SGL,  1, OK, 3'b000, 3'b010, 1, 0);
    // Owner abandons an INCR16 with IDLE: rearbitrate on the following cycle
    add(3'b110, 3'b000, NS,  INC16, 1, OK, 3'b000, 3'b010, 1, 0);
    add(3'b110, 3'b000, SQ,  INC16, 1, OK, 3'b000, 3'b010, 1, 0);
    add(3'b110, 3'b000, IDL, INC16, 1, OK, 3'b000, 3'b010, 1, 0);
    add(3'b110, 3'b000, IDL, SGL,  1, OK, 3'b000, 3'b100, 1, 0);
    add(3'b100, 3'b000, IDL, SGL,  1, OK, 3'b000, 3'b100, 2, 0);
    add(3'b110, 3'b000, NS,  INC4, 1, OK, 3'b000, 3'b100, 2, 0);

    v = vt[0];
    drive(v);
    HRESETn = 1'b0;
    @(posedge HCLK);
    @(posedge HCLK);
    #1;
    cmp("reset_grant", int'(bus.HGRANT), 1);
    cmp("reset_master", int'(bus.HMASTER), 0);
    cmp("reset_mastlock", int'(bus.HMASTLOCK), 0);
    HRESETn = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      apply(vt[i], $sformatf("vec%0d", i));
      if (i == retry_idx)
        cmp("retry_beat_cnt", int'(dut.beat_cnt), 0);
    end

    // Asynchronous reset in the middle of M2's INCR4, between clock edges
    cmp("burst_cnt_before_reset", int'(dut.beat_cnt), 3);
    #2;
    HRESETn = 1'b0;
    #1;
    cmp("async_reset_grant", int'(bus.HGRANT), 1);
    cmp("async_reset_master", int'(bus.HMASTER), 0);
    cmp("async_reset_mastlock", int'(bus.HMASTLOCK), 0);
    cmp("async_reset_beat_cnt", int'(dut.beat_cnt), 0);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;

    v = vt[0];
    apply(v, "post_reset_idle");
    v.req = 3'b110; v.g = 3'b010; v.m = 4'd0;
    apply(v, "post_reset_rr0");
    v.g = 3'b100; v.m = 4'd1;
    apply(v, "post_reset_rr1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
